// File: rtl/ysyx_25040105_ctrl.sv
// Multi-cycle sequencing controller for the ysyx_25040105 core.
// Walks each instruction through FETCH/FWAIT/DECODE/EXEC/MEM/MWAIT/WB, drives the
// imem/dmem request handshakes and the IR/PC/RF strobes, and stops in HALT or ERR.
module ysyx_25040105_ctrl #(
    parameter int unsigned TIMEOUT = 255,
    parameter int unsigned CNT_W   = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             run_en,
    input  logic [7:0]       dec_alu_op,
    input  logic             dec_reg_wen,
    input  logic             dec_mem_wen,
    output logic             imem_req_valid,
    input  logic             imem_req_ready,
    input  logic             imem_rsp_valid,
    output logic             dmem_req_valid,
    output logic             dmem_req_we,
    input  logic             dmem_req_ready,
    input  logic             dmem_rsp_valid,
    output logic             ir_we,
    output logic             pc_wen,
    output logic             rf_wen,
    output logic             halt,
    output logic             err,
    output logic [1:0]       err_code,
    output logic [3:0]       state,
    output logic [CNT_W-1:0] cycle_cnt,
    output logic [CNT_W-1:0] instret_cnt
);

    localparam int unsigned    WdW    = $clog2(TIMEOUT + 1);
    // Last count at which a still-pending wait is allowed to complete.
    localparam logic [WdW-1:0] WdLast = WdW'(TIMEOUT - 1);

    typedef enum logic [3:0] {
        StIdle   = 4'd0,
        StFetch  = 4'd1,
        StFwait  = 4'd2,
        StDecode = 4'd3,
        StExec   = 4'd4,
        StMem    = 4'd5,
        StMwait  = 4'd6,
        StWb     = 4'd7,
        StHalt   = 4'd8,
        StErr    = 4'd9
    } state_e;

    localparam logic [1:0] ErrNone    = 2'd0;
    localparam logic [1:0] ErrIllegal = 2'd1;
    localparam logic [1:0] ErrImemTo  = 2'd2;
    localparam logic [1:0] ErrDmemTo  = 2'd3;

    state_e           state_q, state_d;
    logic [WdW-1:0]   wd_q, wd_d;
    logic [1:0]       err_code_q, err_code_d;
    logic [CNT_W-1:0] cycle_q, instret_q;
    logic             wd_expired;
    logic             waiting;

    // State, watchdog and error-code registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= StIdle;
            wd_q       <= '0;
            err_code_q <= ErrNone;
        end else begin
            state_q    <= state_d;
            wd_q       <= wd_d;
            err_code_q <= err_code_d;
        end
    end

    // Next-state: handshake completion is checked before watchdog expiry so it wins.
    always_comb begin
        state_d    = state_q;
        err_code_d = err_code_q;
        wd_expired = (wd_q == WdLast);
        waiting    = state_q inside {StFetch, StFwait, StMem, StMwait};
        unique case (state_q)
            StIdle: begin
                if (run_en) state_d = StFetch;
            end
            StFetch: begin
                if (imem_req_ready) begin
                    state_d = StFwait;
                end else if (wd_expired) begin
                    state_d    = StErr;
                    err_code_d = ErrImemTo;
                end
            end
            StFwait: begin
                if (imem_rsp_valid) begin
                    state_d = StDecode;
                end else if (wd_expired) begin
                    state_d    = StErr;
                    err_code_d = ErrImemTo;
                end
            end
            StDecode: state_d = StExec;
            StExec: begin
                // Unknown (X/Z) opcodes match no range and fall into the error default.
                case (dec_alu_op) inside
                    [8'h00:8'h1C]: state_d = StWb;
                    [8'h1D:8'h24]: state_d = StMem;
                    8'h25, 8'h26:  state_d = StHalt;
                    default: begin
                        state_d    = StErr;
                        err_code_d = ErrIllegal;
                    end
                endcase
            end
            StMem: begin
                if (dmem_req_ready) begin
                    state_d = StMwait;
                end else if (wd_expired) begin
                    state_d    = StErr;
                    err_code_d = ErrDmemTo;
                end
            end
            StMwait: begin
                if (dmem_rsp_valid) begin
                    state_d = StWb;
                end else if (wd_expired) begin
                    state_d    = StErr;
                    err_code_d = ErrDmemTo;
                end
            end
            StWb:   state_d = StFetch;
            StHalt: state_d = StHalt;
            StErr:  state_d = StErr;
            default: state_d = StIdle;
        endcase

        if (state_d != state_q) begin
            wd_d = '0;
        end else if (waiting) begin
            wd_d = wd_q + WdW'(1);
        end else begin
            wd_d = wd_q;
        end
    end

    // Moore outputs decoded from the current state (ir_we also qualified by the response).
    always_comb begin
        imem_req_valid = 1'b0;
        dmem_req_valid = 1'b0;
        dmem_req_we    = 1'b0;
        ir_we          = 1'b0;
        pc_wen         = 1'b0;
        rf_wen         = 1'b0;
        halt           = 1'b0;
        err            = 1'b0;
        unique case (state_q)
            StFetch: imem_req_valid = 1'b1;
            StFwait: ir_we          = imem_rsp_valid;
            StMem: begin
                dmem_req_valid = 1'b1;
                dmem_req_we    = dec_mem_wen;
            end
            StWb: begin
                pc_wen = 1'b1;
                rf_wen = dec_reg_wen;
            end
            StHalt:  halt = 1'b1;
            StErr:   err  = 1'b1;
            default: ;
        endcase
    end

    // Performance counters; both wrap silently and freeze in IDLE/HALT/ERR.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cycle_q   <= '0;
            instret_q <= '0;
        end else begin
            if (!(state_q inside {StIdle, StHalt, StErr})) cycle_q <= cycle_q + CNT_W'(1);
            if (state_q == StWb) instret_q <= instret_q + CNT_W'(1);
        end
    end

    assign state       = state_q;
    assign err_code    = err_code_q;
    assign cycle_cnt   = cycle_q;
    assign instret_cnt = instret_q;

endmodule

// File: tb/tb_ysyx_25040105_ctrl.sv
// Scoreboard bench for ysyx_25040105_ctrl: the driver plays memories and decoder with
// random wait lengths and pushes expected events; a monitor pops and checks them.
module tb_ysyx_25040105_ctrl;

    localparam int unsigned TO    = 8;
    localparam int unsigned CW    = 4;
    localparam int          CMASK = (1 << CW) - 1;

    localparam int EvFetch  = 0;
    localparam int EvMreq   = 1;
    localparam int EvRetire = 2;
    localparam int EvHalt   = 3;
    localparam int EvErr    = 4;

    logic          clk = 1'b0;
    logic          rst_n = 1'b1;
    logic          run_en = 1'b0;
    logic [7:0]    dec_alu_op = 8'h00;
    logic          dec_reg_wen = 1'b0;
    logic          dec_mem_wen = 1'b0;
    logic          imem_req_valid;
    logic          imem_req_ready = 1'b0;
    logic          imem_rsp_valid = 1'b0;
    logic          dmem_req_valid;
    logic          dmem_req_we;
    logic          dmem_req_ready = 1'b0;
    logic          dmem_rsp_valid = 1'b0;
    logic          ir_we, pc_wen, rf_wen, halt, err;
    logic [1:0]    err_code;
    logic [3:0]    state;
    logic [CW-1:0] cycle_cnt, instret_cnt;

    always #5 clk = ~clk;

    ysyx_25040105_ctrl #(
        .TIMEOUT(TO),
        .CNT_W  (CW)
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .run_en        (run_en),
        .dec_alu_op    (dec_alu_op),
        .dec_reg_wen   (dec_reg_wen),
        .dec_mem_wen   (dec_mem_wen),
        .imem_req_valid(imem_req_valid),
        .imem_req_ready(imem_req_ready),
        .imem_rsp_valid(imem_rsp_valid),
        .dmem_req_valid(dmem_req_valid),
        .dmem_req_we   (dmem_req_we),
        .dmem_req_ready(dmem_req_ready),
        .dmem_rsp_valid(dmem_rsp_valid),
        .ir_we         (ir_we),
        .pc_wen        (pc_wen),
        .rf_wen        (rf_wen),
        .halt          (halt),
        .err           (err),
        .err_code      (err_code),
        .state         (state),
        .cycle_cnt     (cycle_cnt),
        .instret_cnt   (instret_cnt)
    );

    // -1 in a field means "not checked for this event".
    typedef struct {
        int kind;
        int st;
        int rf;
        int we;
        int inst;
        int cyc;
        int ec;
        int reqc;
    } ev_t;

    ev_t sb[$];
    int  n_cmp = 0;
    int  n_fail = 0;
    int  cyc_m = 0;
    int  inst_m = 0;
    int  term_cyc = 0;

    task automatic chk(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at t=%0t", name, act, exp, $time);
        end
    endtask

    // ---------------------------------------------------------------- monitor
    int ireq_cnt = 0;
    int dreq_cnt = 0;
    logic halt_prev = 1'b0;
    logic err_prev = 1'b0;

    task automatic take(input int kind);
        ev_t e;
        if (sb.size() == 0) begin
            chk("unexpected_event", kind, -1);
            return;
        end
        e = sb.pop_front();
        chk("event_kind", kind, e.kind);
        chk("event_state", int'(state), e.st);
        if (e.rf >= 0)   chk("rf_wen", int'(rf_wen), e.rf);
        if (e.we >= 0)   chk("dmem_req_we", int'(dmem_req_we), e.we);
        if (e.inst >= 0) chk("instret_cnt", int'(instret_cnt), e.inst);
        if (e.cyc >= 0)  chk("cycle_cnt", int'(cycle_cnt), e.cyc);
        if (e.ec >= 0)   chk("err_code", int'(err_code), e.ec);
        if (e.reqc >= 0) chk("req_valid_cycles", (kind == EvFetch) ? ireq_cnt : dreq_cnt, e.reqc);
    endtask

    initial begin : monitor
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                ireq_cnt = 0;
                dreq_cnt = 0;
            end else begin
                if (imem_req_valid) ireq_cnt++;
                if (dmem_req_valid) dreq_cnt++;
                chk("we_without_valid", int'(dmem_req_we && !dmem_req_valid), 0);
                chk("irwe_with_pcwen", int'(ir_we && pc_wen), 0);
                chk("rfwen_without_pcwen", int'(rf_wen && !pc_wen), 0);
                if (ir_we) begin
                    take(EvFetch);
                    ireq_cnt = 0;
                end
                if (dmem_req_valid && dmem_req_ready) begin
                    take(EvMreq);
                    dreq_cnt = 0;
                end
                if (pc_wen) take(EvRetire);
                if (halt && !halt_prev) take(EvHalt);
                if (err && !err_prev) take(EvErr);
            end
            halt_prev = halt;
            err_prev  = err;
        end
    end

    // ----------------------------------------------------------------- driver
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic quiet();
        imem_req_ready = 1'b0;
        imem_rsp_valid = 1'b0;
        dmem_req_ready = 1'b0;
        dmem_rsp_valid = 1'b0;
    endtask

    // Random activity on handshake inputs; callers override the one that matters.
    task automatic noise();
        imem_req_ready = 1'($urandom);
        imem_rsp_valid = 1'($urandom);
        dmem_req_ready = 1'($urandom);
        dmem_rsp_valid = 1'($urandom);
    endtask

    task automatic do_reset();
        chk("events_pending", sb.size(), 0);
        #2;
        rst_n = 1'b0;
        #1;
        chk("reset_outputs", int'({imem_req_valid, dmem_req_valid, dmem_req_we, ir_we, pc_wen,
                                   rf_wen, halt, err, err_code, state}), 0);
        chk("reset_cycle_cnt", int'(cycle_cnt), 0);
        chk("reset_instret_cnt", int'(instret_cnt), 0);
        sb.delete();
        quiet();
        run_en = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        cyc_m  = 0;
        inst_m = 0;
        for (int i = 0; i < 3; i++) begin
            noise();
            tick();
            chk("idle_hold", int'(state), 0);
        end
        quiet();
    endtask

    task automatic start();
        run_en = 1'b1;
        tick();
        run_en = 1'b0;
    endtask

    // mode 0: normal, 1: dmem response never comes, 2: reset asserted inside MWAIT.
    task automatic run_instr(input logic [7:0] op, input logic rw, input logic mw,
                             input int dr, input int dp, input int dq, input int dm,
                             input int mode);
        ev_t e;
        bit  is_mem;
        bit  is_halt;
        bit  is_ill;
        int  pre;
        int  memc;
        is_mem  = (op >= 8'h1D) && (op <= 8'h24);
        is_halt = (op == 8'h25) || (op == 8'h26);
        is_ill  = (op > 8'h26);
        pre     = (dr + 1) + (dp + 1) + 2;
        memc    = is_mem ? (dq + 1) + (dm + 1) : 0;

        e = '{EvFetch, 2, -1, -1, -1, -1, -1, dr + 1};
        sb.push_back(e);
        if (is_halt || is_ill) begin
            term_cyc = (cyc_m + pre) & CMASK;
            e = '{is_halt ? EvHalt : EvErr, is_halt ? 8 : 9, -1, -1, inst_m, term_cyc,
                  is_halt ? 0 : 1, -1};
            sb.push_back(e);
        end else begin
            if (is_mem) begin
                e = '{EvMreq, 5, -1, int'(mw), -1, -1, -1, dq + 1};
                sb.push_back(e);
            end
            if (mode == 1) begin
                term_cyc = (cyc_m + pre + dq + 1 + TO) & CMASK;
                e = '{EvErr, 9, -1, -1, inst_m, term_cyc, 3, -1};
                sb.push_back(e);
            end else if (mode == 0) begin
                e = '{EvRetire, 7, int'(rw), -1, inst_m, (cyc_m + pre + memc) & CMASK, -1, -1};
                sb.push_back(e);
            end
        end

        for (int i = 0; i <= dr; i++) begin
            noise();
            imem_req_ready = (i == dr);
            tick();
        end
        for (int i = 0; i <= dp; i++) begin
            noise();
            imem_rsp_valid = (i == dp);
            if (i == dp) begin
                dec_alu_op  = op;
                dec_reg_wen = rw;
                dec_mem_wen = mw;
            end
            tick();
        end
        noise();
        tick();  // DECODE
        noise();
        tick();  // EXEC
        if (is_halt || is_ill) begin
            quiet();
            return;
        end
        if (is_mem) begin
            for (int i = 0; i <= dq; i++) begin
                noise();
                dmem_req_ready = (i == dq);
                tick();
            end
            if (mode == 1) begin
                for (int i = 0; i < int'(TO); i++) begin
                    noise();
                    dmem_rsp_valid = 1'b0;
                    tick();
                end
                quiet();
                return;
            end
            if (mode == 2) begin
                for (int i = 0; i < 3; i++) begin
                    noise();
                    dmem_rsp_valid = 1'b0;
                    tick();
                end
                chk("mwait_before_reset", int'(state), 6);
                do_reset();
                return;
            end
            for (int i = 0; i <= dm; i++) begin
                noise();
                dmem_rsp_valid = (i == dm);
                tick();
            end
        end
        noise();
        tick();  // WB
        quiet();
        cyc_m  = (cyc_m + pre + memc + 1) & CMASK;
        inst_m = (inst_m + 1) & CMASK;
    endtask

    task automatic rand_instr();
        int cls;
        cls = $urandom_range(0, 2);
        if (cls == 0) begin
            run_instr(8'($urandom_range(0, 8'h1C)), 1'($urandom), 1'($urandom),
                      $urandom_range(0, 7), $urandom_range(0, 7), 0, 0, 0);
        end else if (cls == 1) begin
            run_instr(8'($urandom_range(8'h1D, 8'h21)), 1'($urandom), 1'b0,
                      $urandom_range(0, 7), $urandom_range(0, 7),
                      $urandom_range(0, 7), $urandom_range(0, 7), 0);
        end else begin
            run_instr(8'($urandom_range(8'h22, 8'h24)), 1'($urandom), 1'b1,
                      $urandom_range(0, 7), $urandom_range(0, 7),
                      $urandom_range(0, 7), $urandom_range(0, 7), 0);
        end
    endtask

    initial begin : driver
        do_reset();

        // Zero-wait ALU instruction: 5 cycles to retire.
        start();
        run_instr(8'h00, 1'b1, 1'b0, 0, 0, 0, 0, 0);
        chk("first_cycle_cnt", int'(cycle_cnt), 5);
        chk("first_instret", int'(instret_cnt), 1);
        chk("first_back_to_fetch", int'(state), 1);

        // Load with a stalled request, then a store that does not write the RF.
        run_instr(8'h1F, 1'b1, 1'b0, 0, 0, 3, 0, 0);
        run_instr(8'h24, 1'b0, 1'b1, 1, 1, 0, 2, 0);

        // Handshakes completing exactly at the watchdog limit.
        run_instr(8'h05, 1'b1, 1'b0, TO - 1, TO - 1, 0, 0, 0);
        run_instr(8'h1D, 1'b1, 1'b0, 0, 0, TO - 1, TO - 1, 0);

        // Random mix; runs long enough to wrap both 4-bit counters.
        for (int n = 0; n < 40; n++) rand_instr();

        // ECALL/EBREAK halts and freezes everything.
        run_instr(($urandom % 2) ? 8'h25 : 8'h26, 1'b1, 1'b0, $urandom_range(0, 3),
                  $urandom_range(0, 3), 0, 0, 0);
        for (int i = 0; i < 100; i++) begin
            noise();
            run_en = 1'($urandom);
            tick();
        end
        quiet();
        run_en = 1'b0;
        chk("halt_held", int'(halt), 1);
        chk("halt_state", int'(state), 8);
        chk("halt_cycle_frozen", int'(cycle_cnt), term_cyc);
        chk("halt_instret_frozen", int'(instret_cnt), inst_m);

        // Illegal opcode.
        do_reset();
        start();
        rand_instr();
        run_instr(8'($urandom_range(8'h27, 8'hFF)), 1'b1, 1'b0, 0, 1, 0, 0, 0);
        for (int i = 0; i < 20; i++) begin
            noise();
            tick();
        end
        quiet();
        chk("illegal_err_held", int'(err), 1);
        chk("illegal_code_held", int'(err_code), 1);
        chk("illegal_cycle_frozen", int'(cycle_cnt), term_cyc);

        // imem never ready: ERR after TO fetch cycles.
        do_reset();
        start();
        begin
            ev_t e;
            e = '{EvErr, 9, -1, -1, 0, int'(TO) & CMASK, 2, -1};
            sb.push_back(e);
        end
        for (int i = 0; i < int'(TO) + 4; i++) begin
            noise();
            imem_req_ready = 1'b0;
            tick();
        end
        quiet();
        chk("imem_to_state", int'(state), 9);
        chk("imem_to_code", int'(err_code), 2);

        // dmem response never arrives.
        do_reset();
        start();
        rand_instr();
        run_instr(8'h20, 1'b1, 1'b0, $urandom_range(0, 3), $urandom_range(0, 3),
                  $urandom_range(0, 3), 0, 1);
        for (int i = 0; i < 10; i++) begin
            noise();
            tick();
        end
        quiet();
        chk("dmem_to_state", int'(state), 9);
        chk("dmem_to_code", int'(err_code), 3);
        chk("dmem_to_cycle_frozen", int'(cycle_cnt), term_cyc);

        // Reset pulsed while a load waits for its response.
        do_reset();
        start();
        run_instr(8'h1E, 1'b1, 1'b0, 0, 0, 1, 0, 2);
        chk("post_abort_drain", sb.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
